// File: rtl/fwd_regfile_pkg.sv
// Shared definitions for the fwd_regfile GPR block.
// Holds the forwarding-bus record layout. Each source on fwd_bus is packed as
// {wreg, ld_pend, waddr, wdata}, with wdata in the least significant bits.
// The helpers below give the record width and the bit positions of its fields.
package fwd_regfile_pkg;

  // Width of one forwarding-source record.
  function automatic int fwd_w(input int addr_w, input int data_w);
    return 2 + addr_w + data_w;
  endfunction

  // Field offsets inside one record.
  function automatic int fwd_wdata_lsb();
    return 0;
  endfunction

  function automatic int fwd_waddr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int fwd_pend_bit(input int addr_w, input int data_w);
    return data_w + addr_w;
  endfunction

  function automatic int fwd_wreg_bit(input int addr_w, input int data_w);
    return data_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// One read port of fwd_regfile: the priority mux plus hit/pending flags.
// Priority, highest first: r0 reads zero; lowest-index matching forwarding
// source; same-cycle WB write (write-through); stored register value.
// Ports:
//   raddr    in   read address of this port
//   reg_data in   stored value of reg[raddr]
//   we/waddr/wdata in   WB write port, used for write-through
//   fwd_bus  in   NR_FWD packed forwarding records, source 0 youngest
//   rdata    out  selected read data
//   hit      out  a forwarding source won the mux
//   pend     out  the winning source still has a load outstanding
module fwd_sel
  import fwd_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NR_FWD = 3,
  localparam int FWD_W = fwd_w(ADDR_W, DATA_W)
) (
  input  logic [ADDR_W-1:0]       raddr,
  input  logic [DATA_W-1:0]       reg_data,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NR_FWD*FWD_W-1:0] fwd_bus,
  output logic [DATA_W-1:0]       rdata,
  output logic                    hit,
  output logic                    pend
);

  localparam int WDATA_LSB = fwd_wdata_lsb();
  localparam int WADDR_LSB = fwd_waddr_lsb(DATA_W);
  localparam int PEND_BIT  = fwd_pend_bit(ADDR_W, DATA_W);
  localparam int WREG_BIT  = fwd_wreg_bit(ADDR_W, DATA_W);

  logic [FWD_W-1:0]  src;
  logic [ADDR_W-1:0] src_addr;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    rdata    = reg_data;
    hit      = 1'b0;
    pend     = 1'b0;
    src      = '0;
    src_addr = '0;

    if (we && (waddr == raddr)) rdata = wdata;

    // Walk from the oldest source to the youngest so the youngest match is
    // the last assignment and therefore wins.
    for (int s = NR_FWD - 1; s >= 0; s--) begin
      src      = fwd_bus[s*FWD_W +: FWD_W];
      src_addr = src[WADDR_LSB +: ADDR_W];
      if (src[WREG_BIT] && (src_addr != '0) && (src_addr == raddr)) begin
        rdata = src[WDATA_LSB +: DATA_W];
        hit   = 1'b1;
        pend  = src[PEND_BIT];
      end
    end

    // r0 is constant zero regardless of any source or write targeting it.
    if (raddr == '0) begin
      rdata = '0;
      hit   = 1'b0;
      pend  = 1'b0;
    end
  end

endmodule

// File: rtl/fwd_regfile.sv
// GPR file for the 5-stage pipeline, sitting in ID.
// NR_RD combinational read ports with prioritised forwarding from NR_FWD
// sources (0 = EX, youngest), one WB write port with write-through, load-use
// stall detection and a saturating count of stalled cycles. r0 reads zero.
// Optional HI/LO pair, enabled by defining REGFILE_HILO_EN.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   rd_en     in   per-port read valid, only gates stall detection
//   raddr     in   packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rdata     out  packed read data, port p at [p*DATA_W +: DATA_W]
//   we/waddr/wdata in   WB write port
//   fwd_bus   in   NR_FWD records {wreg, ld_pend, waddr, wdata}
//   stall_req out  load-use hazard on some enabled port
//   stall_cnt out  saturating count of cycles with stall_req=1
//   hi_we/lo_we, hi_wdata/lo_wdata in, hi_rdata/lo_rdata out  (REGFILE_HILO_EN only)
module fwd_regfile
  import fwd_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NR_RD  = 2,
  parameter int NR_FWD = 3,
  parameter int CNT_W  = 16,
  localparam int FWD_W = fwd_w(ADDR_W, DATA_W)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NR_RD-1:0]        rd_en,
  input  logic [NR_RD*ADDR_W-1:0] raddr,
  output logic [NR_RD*DATA_W-1:0] rdata,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NR_FWD*FWD_W-1:0] fwd_bus,
  output logic                    stall_req,
  output logic [CNT_W-1:0]        stall_cnt
`ifdef REGFILE_HILO_EN
  ,
  input  logic                    hi_we,
  input  logic                    lo_we,
  input  logic [DATA_W-1:0]       hi_wdata,
  input  logic [DATA_W-1:0]       lo_wdata,
  output logic [DATA_W-1:0]       hi_rdata,
  output logic [DATA_W-1:0]       lo_rdata
`endif
);

  localparam int NR_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NR_REGS];
  logic [DATA_W-1:0] regs_d [NR_REGS];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [NR_RD-1:0]  hit_vec, pend_vec;

  for (genvar p = 0; p < NR_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[p*ADDR_W +: ADDR_W];

    fwd_sel #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NR_FWD(NR_FWD)
    ) u_sel (
      .raddr   (ra),
      .reg_data(regs_q[ra]),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .fwd_bus (fwd_bus),
      .rdata   (rdata[p*DATA_W +: DATA_W]),
      .hit     (hit_vec[p]),
      .pend    (pend_vec[p])
    );
  end

  // A port stalls only if it is really reading and its winning source is a
  // pending load; an older ready match never hides a younger pending one
  // because fwd_sel reports the flags of the winner only.
  assign stall_req = |(rd_en & hit_vec & pend_vec);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_req && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // NOTE: the array sits in the reset domain because every GPR must read zero
  // after reset; this keeps it as flops rather than a RAM macro.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NR_REGS; i++) regs_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      regs_q      <= regs_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef REGFILE_HILO_EN
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  assign hi_d     = hi_we ? hi_wdata : hi_q;
  assign lo_d     = lo_we ? lo_wdata : lo_q;
  // Write-through: the next-state value is exactly the same-cycle read value.
  assign hi_rdata = hi_d;
  assign lo_rdata = lo_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
`endif

endmodule
